// File: rtl/tap_pkg.sv
// Shared TAP definitions: the 1149.1 state encoding and the next-state rule,
// used by the controller and by anything that needs to predict it.
package tap_pkg;

  localparam int TAP_RESET_TMS_COUNT = 5;

  typedef enum logic [3:0] {
    EXIT2_DR   = 4'h0,
    EXIT1_DR   = 4'h1,
    SHIFT_DR   = 4'h2,
    PAUSE_DR   = 4'h3,
    SELECT_IR  = 4'h4,
    UPDATE_DR  = 4'h5,
    CAPTURE_DR = 4'h6,
    SELECT_DR  = 4'h7,
    EXIT2_IR   = 4'h8,
    EXIT1_IR   = 4'h9,
    SHIFT_IR   = 4'hA,
    PAUSE_IR   = 4'hB,
    RTI        = 4'hC,
    UPDATE_IR  = 4'hD,
    CAPTURE_IR = 4'hE,
    TLR        = 4'hF
  } tap_state_e;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TLR;
    case (s)
      TLR:        n = tms ? TLR       : RTI;
      RTI:        n = tms ? SELECT_DR : RTI;
      SELECT_DR:  n = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR: n = tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:   n = tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:   n = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:   n = tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:   n = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:  n = tms ? SELECT_DR : RTI;
      SELECT_IR:  n = tms ? TLR       : CAPTURE_IR;
      CAPTURE_IR: n = tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:   n = tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:   n = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:   n = tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:   n = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:  n = tms ? SELECT_DR : RTI;
      default:    n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tap_controller_if.sv
// Signal bundle between the TAP controller (master) and the IR/DR logic it steers.
interface tap_controller_if #(
    parameter int STATE_W = 4
);
    // No valid/ready handshake: tms is sampled on every rising tck and every
    // output is a level that is valid for the whole tck cycle of its state.
    logic               tms;
    logic               tl_reset;
    logic               captureIR;
    logic               shiftIR;
    logic               updateIR;
    logic               captureDR;
    logic               shiftDR;
    logic               updateDR;
    logic               tck_ir;
    logic               tck_dr;
    logic               ir_sel;
    logic               tdo_en;
    logic [STATE_W-1:0] state;

    modport master (
        input  tms,
        output tl_reset, captureIR, shiftIR, updateIR,
        output captureDR, shiftDR, updateDR,
        output tck_ir, tck_dr, ir_sel, tdo_en, state
    );

    modport slave (
        output tms,
        input  tl_reset, captureIR, shiftIR, updateIR,
        input  captureDR, shiftDR, updateDR,
        input  tck_ir, tck_dr, ir_sel, tdo_en, state
    );
endinterface

// File: rtl/tap_clock_gate.sv
// Latch-based clock gate: enable is only allowed to change while clk is low,
// so the gated clock never produces a runt pulse.
module tap_clock_gate (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic gclk
);
    logic en_l;

    // Reset clears the latch so an aborted scan stops the shift clock at once.
    always_latch begin
        if (!rst_n) begin
            en_l <= 1'b0;
        end else if (!clk) begin
            en_l <= en;
        end
    end

    assign gclk = clk & en_l;
endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: tracks the 16-state FSM on rising tck and drives
// registered capture/shift/update strobes, gated shift clocks and TDO enable.
module tap_controller
    import tap_pkg::*;
#(
    parameter bit TDO_EN_NEGEDGE = 1'b1,
    parameter int STATE_W        = 4
) (
    input  logic              tck,
    input  logic              trst_n,
    tap_controller_if.master  bus
);
    tap_state_e state_q;
    tap_state_e state_d;

    logic tl_reset_q, ir_sel_q;
    logic capture_ir_q, shift_ir_q, update_ir_q;
    logic capture_dr_q, shift_dr_q, update_dr_q;
    logic tdo_en_q;
    logic en_ir, en_dr;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = TLR;
        state_d = tap_next(state_q, bus.tms);
    end

    // Strobes are decoded from the next state and registered, so each output
    // is a clean flop output aligned with the state it names.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tl_reset_q   <= 1'b1;
            ir_sel_q     <= 1'b1;
            capture_ir_q <= 1'b0;
            shift_ir_q   <= 1'b0;
            update_ir_q  <= 1'b0;
            capture_dr_q <= 1'b0;
            shift_dr_q   <= 1'b0;
            update_dr_q  <= 1'b0;
        end else begin
            tl_reset_q   <= (state_d == TLR);
            ir_sel_q     <= (state_d inside {SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR,
                                             PAUSE_IR, EXIT2_IR, UPDATE_IR, TLR});
            capture_ir_q <= (state_d == CAPTURE_IR);
            shift_ir_q   <= (state_d == SHIFT_IR);
            update_ir_q  <= (state_d == UPDATE_IR);
            capture_dr_q <= (state_d == CAPTURE_DR);
            shift_dr_q   <= (state_d == SHIFT_DR);
            update_dr_q  <= (state_d == UPDATE_DR);
        end
    end

    generate
        if (TDO_EN_NEGEDGE) begin : g_tdo_neg
            always_ff @(negedge tck or negedge trst_n) begin
                if (!trst_n) begin
                    tdo_en_q <= 1'b0;
                end else begin
                    tdo_en_q <= (state_q inside {SHIFT_IR, SHIFT_DR});
                end
            end
        end else begin : g_tdo_pos
            always_ff @(posedge tck or negedge trst_n) begin
                if (!trst_n) begin
                    tdo_en_q <= 1'b0;
                end else begin
                    tdo_en_q <= (state_d inside {SHIFT_IR, SHIFT_DR});
                end
            end
        end
    endgenerate

    assign en_ir = (state_q inside {CAPTURE_IR, SHIFT_IR});
    assign en_dr = (state_q inside {CAPTURE_DR, SHIFT_DR});

    tap_clock_gate u_gate_ir (
        .clk   (tck),
        .rst_n (trst_n),
        .en    (en_ir),
        .gclk  (bus.tck_ir)
    );

    tap_clock_gate u_gate_dr (
        .clk   (tck),
        .rst_n (trst_n),
        .en    (en_dr),
        .gclk  (bus.tck_dr)
    );

    assign bus.tl_reset  = tl_reset_q;
    assign bus.ir_sel    = ir_sel_q;
    assign bus.captureIR = capture_ir_q;
    assign bus.shiftIR   = shift_ir_q;
    assign bus.updateIR  = update_ir_q;
    assign bus.captureDR = capture_dr_q;
    assign bus.shiftDR   = shift_dr_q;
    assign bus.updateDR  = update_dr_q;
    assign bus.tdo_en    = tdo_en_q;
    assign bus.state     = STATE_W'(state_q);
endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: table-driven TAP model, per-cycle
// compare process, and directed scans with hand-computed expectations.
module tb_tap_controller;
    import tap_pkg::*;

    logic tck    = 1'b0;
    logic trst_n = 1'b1;
    bit   run_clk = 1'b0;
    bit   chk_en  = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    tap_controller_if #(.STATE_W(4)) bus ();

    tap_controller #(.TDO_EN_NEGEDGE(1'b1), .STATE_W(4)) dut (
        .tck    (tck),
        .trst_n (trst_n),
        .bus    (bus)
    );

    // ---------------- clock ----------------
    always #5 if (run_clk) tck = ~tck;

    // ---------------- model: next-state tables straight from the TAP diagram
    logic [3:0] nxt0 [0:15] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                                4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    logic [3:0] nxt1 [0:15] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                                4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
    logic [3:0] m_state = 4'hF;
    logic [3:0] m_prev  = 4'hF;

    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            m_state = 4'hF;
            m_prev  = 4'hF;
        end else begin
            m_prev  = m_state;
            m_state = bus.tms ? nxt1[m_state] : nxt0[m_state];
        end
    end

    function automatic bit is_shift(input logic [3:0] s);
        return (s == 4'h2) || (s == 4'hA);
    endfunction

    function automatic bit ir_path(input logic [3:0] s);
        return (s == 4'h4) || ((s >= 4'h8) && (s != 4'hC));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- scoreboard: compare every cycle ----------------
    always @(posedge tck) begin
        #2;
        if (chk_en && trst_n) begin
            chk("state",     bus.state,     m_state);
            chk("tl_reset",  bus.tl_reset,  m_state == 4'hF);
            chk("captureIR", bus.captureIR, m_state == 4'hE);
            chk("shiftIR",   bus.shiftIR,   m_state == 4'hA);
            chk("updateIR",  bus.updateIR,  m_state == 4'hD);
            chk("captureDR", bus.captureDR, m_state == 4'h6);
            chk("shiftDR",   bus.shiftDR,   m_state == 4'h2);
            chk("updateDR",  bus.updateDR,  m_state == 4'h5);
            chk("ir_sel",    bus.ir_sel,    ir_path(m_state));
            chk("tck_ir_hi", bus.tck_ir,    (m_prev == 4'hE) || (m_prev == 4'hA));
            chk("tck_dr_hi", bus.tck_dr,    (m_prev == 4'h6) || (m_prev == 4'h2));
            chk("tdo_en_late", bus.tdo_en,  is_shift(m_prev));
            chk("onehot", ($countones({bus.captureIR, bus.shiftIR, bus.updateIR,
                                       bus.captureDR, bus.shiftDR, bus.updateDR}) <= 1), 1);
        end
    end

    always @(negedge tck) begin
        #1;
        if (chk_en && trst_n) begin
            chk("tdo_en",    bus.tdo_en, is_shift(m_state));
            chk("tck_ir_lo", bus.tck_ir, 0);
            chk("tck_dr_lo", bus.tck_dr, 0);
        end
    end

    int ir_pulses = 0;
    int dr_pulses = 0;
    always @(posedge bus.tck_ir) ir_pulses++;
    always @(posedge bus.tck_dr) dr_pulses++;

    // ---------------- driver ----------------
    task automatic step(input logic t, input logic [3:0] exp_st, input string nm);
        @(negedge tck);
        #1 bus.tms = t;
        @(posedge tck);
        #3;
        chk(nm, bus.state, exp_st);
    endtask

    logic [3:0] ir_exp [0:8] = '{4'h7, 4'h4, 4'hE, 4'hA, 4'hA, 4'hA, 4'h9, 4'hD, 4'hC};
    logic       ir_tms [0:8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] pz_exp [0:4] = '{4'h1, 4'h3, 4'h3, 4'h0, 4'h2};
    logic       pz_tms [0:4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] rs_exp [0:4] = '{4'h1, 4'h5, 4'h7, 4'h4, 4'hF};

    int c_cir, c_sir, c_uir, c_tdo, c_sdr, c_udr;

    initial begin
        bus.tms = 1'b1;

        // package rule agrees with the diagram tables
        for (int s = 0; s < 16; s++) begin
            for (int t = 0; t < 2; t++) begin
                chk("pkg_next", tap_next(tap_state_e'(s[3:0]), t[0]),
                    t[0] ? nxt1[s] : nxt0[s]);
            end
        end

        // async reset with tck stopped
        #2 trst_n = 1'b0;
        #1;
        chk("rst_state",    bus.state,     4'hF);
        chk("rst_tl_reset", bus.tl_reset,  1);
        chk("rst_ir_sel",   bus.ir_sel,    1);
        chk("rst_strobes",  {bus.captureIR, bus.shiftIR, bus.updateIR,
                             bus.captureDR, bus.shiftDR, bus.updateDR}, 0);
        chk("rst_gclk",     {bus.tck_ir, bus.tck_dr}, 0);
        chk("rst_tdo_en",   bus.tdo_en,    0);
        #1 trst_n = 1'b1;
        run_clk = 1'b1;
        chk_en  = 1'b1;

        step(1'b1, 4'hF, "tlr_hold");
        step(1'b0, 4'hC, "to_rti");

        // IR scan
        ir_pulses = 0; dr_pulses = 0;
        c_cir = 0; c_sir = 0; c_uir = 0; c_tdo = 0;
        for (int i = 0; i < 9; i++) begin
            step(ir_tms[i], ir_exp[i], "ir_scan");
            c_cir += int'(bus.captureIR);
            c_sir += int'(bus.shiftIR);
            c_uir += int'(bus.updateIR);
            c_tdo += int'(bus.tdo_en);
        end
        chk("ir_capture_cycles", c_cir, 1);
        chk("ir_shift_cycles",   c_sir, 3);
        chk("ir_update_cycles",  c_uir, 1);
        chk("ir_tdo_cycles",     c_tdo, 3);
        chk("ir_tck_pulses",     ir_pulses, 4);
        chk("ir_no_dr_pulses",   dr_pulses, 0);
        chk("model_pin_rti",     m_state, 4'hC);

        // pause path within DR
        step(1'b1, 4'h7, "to_sel_dr");
        step(1'b0, 4'h6, "to_cap_dr");
        step(1'b0, 4'h2, "to_shift_dr");
        dr_pulses = 0; c_sdr = 0; c_udr = 0;
        for (int i = 0; i < 5; i++) begin
            step(pz_tms[i], pz_exp[i], "pause_path");
            c_sdr += int'(bus.shiftDR);
            c_udr += int'(bus.updateDR);
        end
        chk("pause_shift_resumed", bus.shiftDR, 1);
        chk("pause_shift_cycles",  c_sdr, 1);
        chk("pause_no_update",     c_udr, 0);
        chk("pause_tck_pulses",    dr_pulses, 1);
        chk("model_pin_shift_dr",  m_state, 4'h2);

        // five tms=1 edges from Shift-DR reach TLR
        c_udr = 0;
        for (int i = 0; i < TAP_RESET_TMS_COUNT; i++) begin
            step(1'b1, rs_exp[i], "sync_reset");
            c_udr += int'(bus.updateDR);
        end
        chk("sync_tl_reset",   bus.tl_reset, 1);
        chk("sync_update_one", c_udr, 1);
        step(1'b1, 4'hF, "tlr_hold2");

        // reset in the middle of Shift-IR
        step(1'b0, 4'hC, "mid_rti");
        step(1'b1, 4'h7, "mid_sel_dr");
        step(1'b1, 4'h4, "mid_sel_ir");
        step(1'b0, 4'hE, "mid_cap_ir");
        step(1'b0, 4'hA, "mid_shift_ir");
        step(1'b0, 4'hA, "mid_shift_ir2");
        chk("mid_tck_ir_running", bus.tck_ir, 1);
        trst_n = 1'b0;
        #1;
        chk("mid_state",    bus.state,    4'hF);
        chk("mid_tl_reset", bus.tl_reset, 1);
        chk("mid_updateIR", bus.updateIR, 0);
        chk("mid_shiftIR",  bus.shiftIR,  0);
        chk("mid_tck_ir",   bus.tck_ir,   0);
        chk("mid_tdo_en",   bus.tdo_en,   0);
        #2 trst_n = 1'b1;

        // random tms, checked every cycle by the scoreboard
        repeat (10000) begin
            @(negedge tck);
            #1 bus.tms = 1'($urandom_range(0, 1));
        end
        @(negedge tck);
        #2;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tap_controller.md
Name: tap_controller

Overview:
- IEEE 1149.1 TAP state machine. It sits directly upstream of the instruction register and the data registers.
- Samples TMS on rising TCK and tracks the 16-state TAP FSM.
- Produces glitch-free control strobes (tl_reset, captureIR/shiftIR/updateIR, captureDR/shiftDR/updateDR), gated shift clocks tck_ir/tck_dr, the IR/DR path select and the TDO output enable.

Parameters:
- TDO_EN_NEGEDGE, 1, 1: tdo_en is registered on falling tck (1149.1 timing). 0: registered on rising tck.
- STATE_W, 4, width of the state register. Fixed at 4; exists only for the debug port.

Ports:
- tck  input  1  test clock; the only clock.
- trst_n  input  1  asynchronous, active-low test reset.
- tms  input  1  test mode select, sampled on rising tck.
- tl_reset  output  1  high while in Test-Logic-Reset.
- captureIR  output  1  high while in Capture-IR.
- shiftIR  output  1  high while in Shift-IR.
- updateIR  output  1  high while in Update-IR; glitch-free, because downstream uses it as a clock edge.
- captureDR  output  1  high while in Capture-DR.
- shiftDR  output  1  high while in Shift-DR.
- updateDR  output  1  high while in Update-DR.
- tck_ir  output  1  tck gated on while in Capture-IR or Shift-IR.
- tck_dr  output  1  tck gated on while in Capture-DR or Shift-DR.
- ir_sel  output  1  1 = IR path selected for the TDO mux.
- tdo_en  output  1  TDO driver enable.
- state  output  STATE_W  current state, for debug and verification.

Behaviour:
- Clock and reset:
  - One clock, tck. Reset trst_n is asynchronous and active-low.
  - trst_n low forces state = TLR (4'hF) immediately.
  - Reset values: tl_reset=1, ir_sel=1; all other strobes 0; tck_ir=tck_dr=0; tdo_en=0.
  - Reset mid-operation (e.g. mid Shift-IR) aborts the scan with no update strobe.
- State encoding (1149.1 standard):
  - Exit2-DR=0, Exit1-DR=1, Shift-DR=2, Pause-DR=3
  - Select-IR=4, Update-DR=5, Capture-DR=6, Select-DR=7
  - Exit2-IR=8, Exit1-IR=9, Shift-IR=A, Pause-IR=B
  - RTI=C, Update-IR=D, Capture-IR=E, TLR=F
- Transitions on rising tck, listed as (tms=0 / tms=1):
  - TLR: RTI/TLR. RTI: RTI/Select-DR.
  - Select-DR: Capture-DR/Select-IR. Capture-DR: Shift-DR/Exit1-DR. Shift-DR: Shift-DR/Exit1-DR.
  - Exit1-DR: Pause-DR/Update-DR. Pause-DR: Pause-DR/Exit2-DR. Exit2-DR: Shift-DR/Update-DR. Update-DR: RTI/Select-DR.
  - Select-IR: Capture-IR/TLR. The IR column mirrors the DR column.
- Strobes:
  - Decoded from next_state and registered on rising tck, so each strobe is high for exactly the tck cycle the FSM occupies that state.
  - No combinational decode reaches an output, so updateIR/updateDR are glitch-free.
- ir_sel: 1 in Select-IR through Update-IR, and in TLR; 0 elsewhere.
- tdo_en:
  - 1 iff the state is Shift-IR or Shift-DR.
  - Registered on falling tck when TDO_EN_NEGEDGE=1, so it changes half a cycle after the state.
- Gated clocks:
  - tck_ir = tck AND en_ir, with en_ir = (state is Capture-IR or Shift-IR). tck_dr is the same for DR.
  - en is captured by a latch transparent while tck is low, giving no runt pulses.
- Five or more consecutive tms=1 edges reach TLR from any state.
- TLR holds while tms=1. RTI, Shift and Pause states hold while tms=0.
- Simultaneous trst_n assertion and a tck edge: reset wins.

Decomposition:
- Package tap_pkg:
  - tap_state_e enum with the standard encodings above.
  - Localparam TAP_RESET_TMS_COUNT=5.
  - Function tap_next(state, tms) used by both RTL and the bench model.
- Sub-module tap_clock_gate:
  - Latch-based ICG: tck, en → gated clock.
  - Instantiated twice, for tck_ir and tck_dr.

Test Plan:
- Async reset: trst_n=0 with tck stopped → state=F, tl_reset=1, ir_sel=1, all other outputs 0, without any clock edge.
- IR scan: from RTI, tms sequence 1,1,0,0,0,0,1,1,0.
  - States visited: 7, 4, E, A, A, A, 9, D, C.
  - captureIR high 1 cycle, shiftIR high 3 cycles, updateIR high 1 cycle.
  - tck_ir pulses 4 times; tdo_en high for 3 cycles, shifted half a cycle late.
- Pause path: in Shift-DR, tms 1,0,0,1,0 → states 1, 3, 3, 0, 2.
  - shiftDR resumes; tck_dr is gated off in Pause-DR/Exit states.
  - updateDR never fires.
- Sync reset: from Shift-DR (state=2), five tms=1 edges → state=F after the 5th edge, tl_reset=1; no updateDR glitch beyond the single Update-DR pass.
- Reset mid-shift: in Shift-IR, trst_n low for 3 ns → state=F immediately, updateIR stays 0, tck_ir stops.
- Random tms for 10k edges: state matches tap_next model every edge; strobes are one-hot among the six capture/shift/update signals; tdo_en implies a shift state.
